// File: rtl/amul_error_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : amul_pkg
//  Purpose  : Shared types and default widths for the approximate-multiplier
//             error meter (state encoding, operand / counter / accumulator
//             widths).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package amul_pkg;

   localparam int unsigned c_DEF_W     = 8;                      // operand width
   localparam int unsigned c_DEF_CNT_W = 17;                     // holds 65536
   localparam int unsigned c_DEF_SUM_W = 2*c_DEF_W + c_DEF_CNT_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } amul_state_t;

endpackage
`default_nettype wire

// File: rtl/amul_error_meter_if.sv
`default_nettype none
// ============================================================================
//  Module   : amul_error_meter_if
//  Purpose  : Triple stream (a, b, y, last) with valid/ready handshake that
//             carries operand/product samples from the multiplier under test
//             into the error meter.
//  Ports    : master -> drives in_valid, a, b, y, last; samples in_ready
//             slave  -> samples in_valid, a, b, y, last; drives in_ready
//  Revision : 1.0  initial release
// ============================================================================
interface amul_error_meter_if
   import amul_pkg::*;
#(
   parameter int unsigned W = c_DEF_W
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] y;
   logic           last;

   modport master (output in_valid, a, b, y, last, input  in_ready);
   modport slave  (input  in_valid, a, b, y, last, output in_ready);
endinterface
`default_nettype wire

// File: rtl/amul_ed_stage.sv
`default_nettype none
// ============================================================================
//  Module   : amul_ed_stage
//  Purpose  : Pipeline stages S1 and S2 of the error meter. S1 captures the
//             accepted triple, S2 holds the absolute error distance
//             |a*b - y| against the exact product, an exact-match flag and
//             the operands that produced it.
//  Ports    : clk, rst_n        clock, asynchronous active-low reset
//             i_flush           drops all in-flight samples (valids only)
//             i_fire            triple accepted this cycle
//             i_a, i_b, i_y     operands and approximate product
//             o_valid           S2 sample valid
//             o_ed, o_exact     error distance, ed == 0
//             o_a, o_b          operands belonging to o_ed
//  Revision : 1.0  initial release
// ============================================================================
module amul_ed_stage
   import amul_pkg::*;
#(
   parameter int unsigned W = c_DEF_W
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   input  wire logic           i_flush,
   input  wire logic           i_fire,
   input  wire logic [W-1:0]   i_a,
   input  wire logic [W-1:0]   i_b,
   input  wire logic [2*W-1:0] i_y,
   output logic                o_valid,
   output logic [2*W-1:0]      o_ed,
   output logic                o_exact,
   output logic [W-1:0]        o_a,
   output logic [W-1:0]        o_b
);

   logic           r_s1_valid;
   logic [W-1:0]   r_s1_a;
   logic [W-1:0]   r_s1_b;
   logic [2*W-1:0] r_s1_y;

   logic           r_s2_valid;
   logic [2*W-1:0] r_s2_ed;
   logic           r_s2_exact;
   logic [W-1:0]   r_s2_a;
   logic [W-1:0]   r_s2_b;

   logic [2*W-1:0] w_prod;
   logic [2*W-1:0] w_ed;

   assign w_prod = {{W{1'b0}}, r_s1_a} * {{W{1'b0}}, r_s1_b};
   // Over- and under-estimates both count as positive distance.
   assign w_ed   = (w_prod >= r_s1_y) ? (w_prod - r_s1_y) : (r_s1_y - w_prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_y     <= '0;
         r_s2_valid <= 1'b0;
         r_s2_ed    <= '0;
         r_s2_exact <= 1'b0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
      end else begin
         r_s1_valid <= i_fire && !i_flush;
         if (i_fire) begin
            r_s1_a <= i_a;
            r_s1_b <= i_b;
            r_s1_y <= i_y;
         end
         r_s2_valid <= r_s1_valid && !i_flush;
         if (r_s1_valid) begin
            r_s2_ed    <= w_ed;
            r_s2_exact <= (w_ed == '0);
            r_s2_a     <= r_s1_a;
            r_s2_b     <= r_s1_b;
         end
      end
   end

   assign o_valid = r_s2_valid;
   assign o_ed    = r_s2_ed;
   assign o_exact = r_s2_exact;
   assign o_a     = r_s2_a;
   assign o_b     = r_s2_b;

endmodule
`default_nettype wire

// File: rtl/amul_error_meter.sv
`default_nettype none
// ============================================================================
//  Module   : amul_error_meter
//  Purpose  : Streaming accuracy meter for 8x8 approximate multipliers.
//             Accepts (a, b, y) triples, computes |a*b - y| and accumulates
//             sample count, exact-match count, sum of error distances and
//             the maximum error distance with its operands. All counters
//             saturate at all-ones and set the sticky sat flag.
//  Ports    : clk, rst_n     clock, asynchronous active-low reset
//             start          clears statistics and enters RUN (any state)
//             s_if (slave)   in_valid/in_ready handshake, a, b, y, last
//             busy, done     RUN|DRAIN, DONE
//             sat            sticky saturation flag
//             n_samples, n_exact, sum_ed, max_ed, max_a, max_b, sum_sq_ed
//  Config   : AMUL_ERR_SQUARED_EN -- when defined, also accumulates ed*ed
//             into sum_sq_ed; otherwise sum_sq_ed is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module amul_error_meter
   import amul_pkg::*;
#(
   parameter int unsigned W     = c_DEF_W,
   parameter int unsigned CNT_W = c_DEF_CNT_W,
   parameter int unsigned SUM_W = 2*W + CNT_W
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          start,
   amul_error_meter_if.slave  s_if,
   output logic               busy,
   output logic               done,
   output logic               sat,
   output logic [CNT_W-1:0]   n_samples,
   output logic [CNT_W-1:0]   n_exact,
   output logic [SUM_W-1:0]   sum_ed,
   output logic [2*W-1:0]     max_ed,
   output logic [W-1:0]       max_a,
   output logic [W-1:0]       max_b,
   output logic [2*SUM_W-1:0] sum_sq_ed
);

   // ---------------------------------------------------------------- FSM
   amul_state_t r_state;
   logic        r_in_ready;
   logic        r_busy;
   logic        r_done;
   logic        r_drain_cnt;
   logic        w_accept;

   // start wins over a coincident accept: that triple is dropped.
   assign w_accept = s_if.in_valid && r_in_ready && !start;

   // in_ready is registered, so it rises one cycle after entering RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_drain_cnt <= 1'b0;
      end else if (start) begin
         r_state     <= ST_RUN;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_drain_cnt <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_accept && s_if.last) begin
                  r_state     <= ST_DRAIN;
                  r_in_ready  <= 1'b0;
                  r_drain_cnt <= 1'b0;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            // Two cycles: exactly the S2 + S3 latency of the last sample.
            ST_DRAIN: begin
               if (r_drain_cnt) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_if.in_ready = r_in_ready;
   assign busy          = r_busy;
   assign done          = r_done;

   // ------------------------------------------------------------ S1 / S2
   logic           w_s2_valid;
   logic [2*W-1:0] w_s2_ed;
   logic           w_s2_exact;
   logic [W-1:0]   w_s2_a;
   logic [W-1:0]   w_s2_b;

   amul_ed_stage #(
      .W (W)
   ) u_ed_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (start),
      .i_fire  (w_accept),
      .i_a     (s_if.a),
      .i_b     (s_if.b),
      .i_y     (s_if.y),
      .o_valid (w_s2_valid),
      .o_ed    (w_s2_ed),
      .o_exact (w_s2_exact),
      .o_a     (w_s2_a),
      .o_b     (w_s2_b)
   );

   // ----------------------------------------------------------------- S3
   logic [CNT_W-1:0] r_n_samples;
   logic [CNT_W-1:0] r_n_exact;
   logic [SUM_W-1:0] r_sum_ed;
   logic [2*W-1:0]   r_max_ed;
   logic [W-1:0]     r_max_a;
   logic [W-1:0]     r_max_b;
   logic             r_sat;

   // One extra bit on each adder exposes the carry used for saturation.
   logic [CNT_W:0]   w_ns_inc;
   logic [CNT_W:0]   w_ne_inc;
   logic [SUM_W:0]   w_sum_inc;
   logic             w_sq_ovf;
   logic             w_ovf;

   assign w_ns_inc  = {1'b0, r_n_samples} + (CNT_W+1)'(1);
   assign w_ne_inc  = {1'b0, r_n_exact}   + (CNT_W+1)'(1);
   assign w_sum_inc = {1'b0, r_sum_ed}    + (SUM_W+1)'(w_s2_ed);
   assign w_ovf     = w_ns_inc[CNT_W] | (w_s2_exact & w_ne_inc[CNT_W])
                    | w_sum_inc[SUM_W] | w_sq_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n_samples <= '0;
         r_n_exact   <= '0;
         r_sum_ed    <= '0;
         r_max_ed    <= '0;
         r_max_a     <= '0;
         r_max_b     <= '0;
         r_sat       <= 1'b0;
      end else if (start) begin
         r_n_samples <= '0;
         r_n_exact   <= '0;
         r_sum_ed    <= '0;
         r_max_ed    <= '0;
         r_max_a     <= '0;
         r_max_b     <= '0;
         r_sat       <= 1'b0;
      end else if (w_s2_valid) begin
         r_n_samples <= w_ns_inc[CNT_W] ? '1 : w_ns_inc[CNT_W-1:0];
         if (w_s2_exact) begin
            r_n_exact <= w_ne_inc[CNT_W] ? '1 : w_ne_inc[CNT_W-1:0];
         end
         r_sum_ed <= w_sum_inc[SUM_W] ? '1 : w_sum_inc[SUM_W-1:0];
         // Strictly greater: ties keep the earliest operands.
         if (w_s2_ed > r_max_ed) begin
            r_max_ed <= w_s2_ed;
            r_max_a  <= w_s2_a;
            r_max_b  <= w_s2_b;
         end
         if (w_ovf) begin
            r_sat <= 1'b1;
         end
      end
   end

`ifdef AMUL_ERR_SQUARED_EN
   logic [4*W-1:0]     w_sq;
   logic [2*SUM_W:0]   w_sq_inc;
   logic [2*SUM_W-1:0] r_sum_sq;

   assign w_sq     = {{(2*W){1'b0}}, w_s2_ed} * {{(2*W){1'b0}}, w_s2_ed};
   assign w_sq_inc = {1'b0, r_sum_sq} + (2*SUM_W+1)'(w_sq);
   assign w_sq_ovf = w_s2_valid & w_sq_inc[2*SUM_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum_sq <= '0;
      end else if (start) begin
         r_sum_sq <= '0;
      end else if (w_s2_valid) begin
         r_sum_sq <= w_sq_inc[2*SUM_W] ? '1 : w_sq_inc[2*SUM_W-1:0];
      end
   end

   assign sum_sq_ed = r_sum_sq;
`else
   assign w_sq_ovf  = 1'b0;
   assign sum_sq_ed = '0;
`endif

   assign n_samples = r_n_samples;
   assign n_exact   = r_n_exact;
   assign sum_ed    = r_sum_ed;
   assign max_ed    = r_max_ed;
   assign max_a     = r_max_a;
   assign max_b     = r_max_b;
   assign sat       = r_sat;

endmodule
`default_nettype wire
